length_packing_pipe: RTL and testbench

- Parametrised elastic pipeline register for the length-packing stage of the compressor.
- Carries the packing control bundle and the data word across DEPTH registered stages.
- Adds a valid/ready handshake with full-throughput skid buffering, synchronous flush and an occupancy count.
- Placed between the length/shift computation and the packing shifter; it lets the downstream packer stall without losing words.

---
 rtl/lp_pkg.sv | 28 ++
 rtl/lp_skid_stage.sv | 55 +++++
 rtl/length_packing_pipe.sv | 71 +++++++
 tb/tb_length_packing_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared types for the length-packing pipeline: control bundle layout and field widths.
package lp_pkg;

  localparam int SHIFT_W  = 8;
  localparam int ENC_W    = 3;
  localparam int LEN_W    = 6;
  localparam int LOC_W    = 4;
  localparam int TOTLEN_W = 7;

  typedef struct packed {
    logic                store;
    logic                fill;
    logic                emit;
    logic                stop;
    logic                fill_ctrl;
    logic [SHIFT_W-1:0]  shift_amount;
    logic [ENC_W-1:0]    encoded1;
    logic [ENC_W-1:0]    encoded2;
    logic [LEN_W-1:0]    length1;
    logic [LEN_W-1:0]    length2;
    logic [LOC_W-1:0]    location2;
    logic [LOC_W-1:0]    location4;
    logic [TOTLEN_W-1:0] total_length;
  } lp_ctrl_t;

  localparam int LP_CTRL_W = $bits(lp_ctrl_t);

endpackage

// File: rtl/lp_skid_stage.sv
// One registered stage with a single-entry skid buffer; 1 cycle latency, full throughput.
// Upstream ready is registered (~skid_vld), so dn_rdy never reaches up_rdy combinationally.
module lp_skid_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 up_vld,
  output logic                 up_rdy,
  input  logic [PAYLOAD_W-1:0] up_dat,
  output logic                 dn_vld,
  input  logic                 dn_rdy,
  output logic [PAYLOAD_W-1:0] dn_dat
);

  logic                 main_vld;
  logic                 skid_vld;
  logic [PAYLOAD_W-1:0] main_dat;
  logic [PAYLOAD_W-1:0] skid_dat;
  logic                 take;
  logic                 advance;

  assign up_rdy  = ~skid_vld;
  assign dn_vld  = main_vld;
  assign dn_dat  = main_dat;
  assign take    = up_vld & ~skid_vld;
  assign advance = ~main_vld | dn_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (advance) begin
      // A parked skid entry always goes first; up_rdy was low, so nothing new arrives.
      if (skid_vld) begin
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= take;
        if (take) main_dat <= up_dat;
      end
    end else if (take) begin
      skid_dat <= up_dat;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/length_packing_pipe.sv
// Elastic DEPTH-stage pipe for {ctrl, word}; DEPTH cycles latency, 1 entry/cycle sustained.
// Each stage skid-buffers so the packer can stall; o_ready drops only when stage 0's skid is full.
module length_packing_pipe
  import lp_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int CTRL_W = LP_CTRL_W,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [WIDTH-1:0]  i_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [WIDTH-1:0]  o_word,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PW = CTRL_W + WIDTH;

  logic          vld [DEPTH+1];
  logic          rdy [DEPTH+1];
  logic [PW-1:0] dat [DEPTH+1];
  logic          in_xfer;
  logic          out_xfer;
  logic [CNT_W-1:0] count;

  assign vld[0]     = i_valid;
  assign dat[0]     = {i_ctrl, i_word};
  assign rdy[DEPTH] = i_ready;
  assign o_ready    = rdy[0];
  assign o_valid    = vld[DEPTH];
  assign {o_ctrl, o_word} = dat[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    lp_skid_stage #(.PAYLOAD_W(PW)) u_stage (
      .clk    (i_clk),
      .reset  (i_reset),
      .flush  (i_flush),
      .up_vld (vld[g]),
      .up_rdy (rdy[g]),
      .up_dat (dat[g]),
      .dn_vld (vld[g+1]),
      .dn_rdy (rdy[g+1]),
      .dn_dat (dat[g+1])
    );
  end

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  // Occupancy tracks main+skid valids across all stages, bounded by 2*DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_length_packing_pipe.sv
// Randomised + directed bench for length_packing_pipe against a queue-based reference model.
module tb_length_packing_pipe;

  localparam int WIDTH  = 64;
  localparam int CTRL_W = 46;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(2*DEPTH+1);
  localparam int PW     = CTRL_W + WIDTH;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [CTRL_W-1:0] i_ctrl = '0;
  logic [WIDTH-1:0]  i_word = '0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [CTRL_W-1:0] o_ctrl;
  logic [WIDTH-1:0]  o_word;
  logic [CNT_W-1:0]  o_count;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [PW-1:0] q[$];
  logic [PW-1:0] prev;
  logic          in_x, out_x;

  length_packing_pipe #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ctrl  (i_ctrl),
    .i_word  (i_word),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ctrl  (o_ctrl),
    .o_word  (o_word),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted entries queue in order; the head must match the output,
  // the count equals what is held, and outputs freeze while nothing is valid.
  always @(negedge clk) begin
    if (checking && !i_reset) begin
      chk("count_vs_model", 128'(o_count), 128'(q.size()));
      chk("count_bound", 128'(o_count <= CNT_W'(2*DEPTH)), 128'(1));
      if (o_count == CNT_W'(2*DEPTH)) chk("ready_low_when_full", 128'(o_ready), 128'(0));
      if (o_valid) begin
        chk("head_exists", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) chk("head_payload", 128'({o_ctrl, o_word}), 128'(q[0]));
      end else begin
        chk("idle_hold", 128'({o_ctrl, o_word}), 128'(prev));
      end
    end
    prev  = {o_ctrl, o_word};
    in_x  = i_valid & o_ready;
    out_x = o_valid & i_ready;
    if (i_reset) begin
      q.delete();
      prev = '0;
    end else begin
      if (out_x && q.size() != 0) void'(q.pop_front());
      if (i_flush) q.delete();
      else if (in_x) q.push_back({i_ctrl, i_word});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [WIDTH-1:0] w);
    logic [63:0] r;
    i_valid = v;
    i_word  = w;
    r       = {$urandom(), $urandom()};
    i_ctrl  = r[CTRL_W-1:0];
  endtask

  initial begin
    int acc;
    bit seen;
    logic [63:0] rw;

    // 1. Reset with valid input offered
    i_reset = 1'b1;
    offer(1'b1, 64'hDEAD);
    tick();
    tick();
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_word", 128'(o_word), 128'(0));
    chk("rst_ctrl", 128'(o_ctrl), 128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    i_reset = 1'b0;
    offer(1'b0, 64'h0);
    checking = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_nothing_out", 128'(o_valid), 128'(0));

    // 2. Streaming 1..8 with downstream always ready
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 64'(i + 1));
      tick();
      if (i == 0) begin
        chk("stream_first_latency", 128'(o_valid), 128'(0));
        chk("stream_count_first", 128'(o_count), 128'(1));
      end else begin
        chk("stream_valid", 128'(o_valid), 128'(1));
        chk("stream_word", 128'(o_word), 128'(i));
        chk("stream_count", 128'(o_count), 128'(2));
      end
    end
    offer(1'b0, 64'h0);
    tick();
    chk("stream_last", 128'(o_word), 128'(8));
    tick();
    chk("stream_drained", 128'(o_count), 128'(0));

    // 3. Backpressure: fill with i_ready low, then release
    i_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 64'(16 + acc));
      if (o_ready) acc++;
      tick();
    end
    chk("bp_accepts", 128'(acc), 128'(4));
    chk("bp_count_full", 128'(o_count), 128'(4));
    chk("bp_ready_low", 128'(o_ready), 128'(0));
    offer(1'b0, 64'h0);
    i_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_valid", 128'(o_valid), 128'(1));
      chk("bp_drain_word", 128'(o_word), 128'(16 + j));
      tick();
    end
    chk("bp_drain_empty", 128'(o_valid), 128'(0));

    // 4. Random valid/ready traffic
    for (int c = 0; c < 2000; c++) begin
      rw = {$urandom(), $urandom()};
      offer(1'($urandom_range(0, 2) != 0), rw);
      i_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    offer(1'b0, 64'h0);
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rand_drained", 128'(o_count), 128'(0));

    // 5. Flush at count 3 while offering 0xAA
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 64'(32 + i));
      tick();
    end
    chk("flush_pre_count", 128'(o_count), 128'(3));
    offer(1'b1, 64'hAA);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    offer(1'b0, 64'h0);
    chk("flush_valid", 128'(o_valid), 128'(0));
    chk("flush_count", 128'(o_count), 128'(0));
    chk("flush_ready", 128'(o_ready), 128'(1));
    i_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_valid) seen = 1'b1;
    end
    chk("flush_no_aa", 128'(seen), 128'(0));

    // 6. Reset while full and stalled, then single word latency
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 64'(48 + i));
      tick();
    end
    chk("mrst_pre_count", 128'(o_count), 128'(4));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    offer(1'b0, 64'h0);
    chk("mrst_valid", 128'(o_valid), 128'(0));
    chk("mrst_count", 128'(o_count), 128'(0));
    chk("mrst_ctrl", 128'(o_ctrl), 128'(0));
    chk("mrst_word", 128'(o_word), 128'(0));
    chk("mrst_ready", 128'(o_ready), 128'(1));
    i_ready = 1'b1;
    offer(1'b1, 64'h55);
    tick();
    offer(1'b0, 64'h0);
    chk("mrst_lat_early", 128'(o_valid), 128'(0));
    tick();
    chk("mrst_lat_valid", 128'(o_valid), 128'(1));
    chk("mrst_lat_word", 128'(o_word), 128'(64'h55));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
